// File: rtl/pixel_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pixel_loader                                                              |
// | Byte-serial loader for eight 3x3 binary kernels and a 28x28 binary image. |
// | Optional: define LOADER_CHKSUM_EN for a trailing XOR check byte.          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pixel_loader #(
  parameter logic [2:0] LOAD_STATE = 3'b001
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                state,
  input  logic [7:0]                data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic [7:0][2:0][2:0]      weights,
  output logic [27:0][27:0]         pixels,
  output logic                      load_done,
  output logic                      chk_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_P = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } fsm_t;

  localparam logic [6:0] c_W_LAST = 7'd8;
  localparam logic [6:0] c_P_LAST = 7'd97;

  fsm_t         r_fsm;
  logic [6:0]   r_cnt;
  logic [71:0]  r_weights;
  logic [783:0] r_pixels;
  logic         r_load_done;
  logic         w_load_ok;
  logic         w_active;

  assign w_load_ok  = (state == LOAD_STATE);
  assign w_active   = (r_fsm == LOAD_W) || (r_fsm == LOAD_P) || (r_fsm == CHECK);
  assign data_ready = w_active && w_load_ok;

  // Packed output arrays flatten to index num*9+r*3+c and row*28+col.
  assign weights    = r_weights;
  assign pixels     = r_pixels;
  assign load_done  = r_load_done;

`ifdef LOADER_CHKSUM_EN
  logic [7:0] r_xor;
  logic       r_chk_err;
  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_cnt       <= '0;
      r_weights   <= '0;
      r_pixels    <= '0;
      r_load_done <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      r_xor       <= '0;
      r_chk_err   <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_load_ok) begin
            r_fsm <= LOAD_W;
            r_cnt <= '0;
`ifdef LOADER_CHKSUM_EN
            r_xor     <= '0;
            r_chk_err <= 1'b0;
`endif
          end
        end

        LOAD_W: begin
          if (!w_load_ok) begin
            r_fsm <= IDLE;
            r_cnt <= '0;
          end else if (data_valid) begin
            r_weights[{r_cnt[3:0], 3'b000} +: 8] <= data_in;
`ifdef LOADER_CHKSUM_EN
            r_xor <= r_xor ^ data_in;
`endif
            if (r_cnt == c_W_LAST) begin
              r_fsm <= LOAD_P;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end

        LOAD_P: begin
          if (!w_load_ok) begin
            r_fsm <= IDLE;
            r_cnt <= '0;
          end else if (data_valid) begin
            r_pixels[{r_cnt, 3'b000} +: 8] <= data_in;
`ifdef LOADER_CHKSUM_EN
            r_xor <= r_xor ^ data_in;
`endif
            if (r_cnt == c_P_LAST) begin
              r_cnt <= '0;
`ifdef LOADER_CHKSUM_EN
              r_fsm <= CHECK;
`else
              r_fsm       <= DONE;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end

`ifdef LOADER_CHKSUM_EN
        CHECK: begin
          if (!w_load_ok) begin
            r_fsm <= IDLE;
            r_cnt <= '0;
          end else if (data_valid) begin
            r_chk_err   <= (data_in != r_xor);
            r_fsm       <= DONE;
            r_load_done <= 1'b1;
          end
        end
`endif

        DONE: begin
          if (state == 3'b000) begin
            r_fsm       <= IDLE;
            r_load_done <= 1'b0;
          end
        end

        default: begin
          r_fsm       <= IDLE;
          r_cnt       <= '0;
          r_load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pixel_loader                                                           |
// | Randomized self-checking bench for pixel_loader against a byte-map model. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pixel_loader;

`ifdef LOADER_CHKSUM_EN
  localparam int FRAME_LEN = 108;
`else
  localparam int FRAME_LEN = 107;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           state;
  logic [7:0]           data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic [7:0][2:0][2:0] weights;
  logic [27:0][27:0]    pixels;
  logic                 load_done;
  logic                 chk_err;

  pixel_loader #(.LOAD_STATE(3'b001)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .weights    (weights),
    .pixels     (pixels),
    .load_done  (load_done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] frame [FRAME_LEN];
  logic [7:0] frame_b [FRAME_LEN];
  logic [7:0] mem_w [9];
  logic [7:0] mem_p [98];
  logic       exp_err;

  task automatic check(input string tag, input logic [783:0] got, input logic [783:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    foreach (mem_w[i]) mem_w[i] = 8'h00;
    foreach (mem_p[i]) mem_p[i] = 8'h00;
    exp_err = 1'b0;
  endtask

  // Expected kernels/image come straight from the bit-index mapping rules.
  task automatic check_all(input string tag, input logic exp_done);
    logic [7:0][2:0][2:0] ew;
    logic [27:0][27:0]    ep;
    logic [7:0]           b;
    int                   k;
    for (int num = 0; num < 8; num++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          k = num * 9 + r * 3 + c;
          b = mem_w[k / 8];
          ew[num][r][c] = b[k % 8];
        end
    for (int row = 0; row < 28; row++)
      for (int col = 0; col < 28; col++) begin
        k = row * 28 + col;
        b = mem_p[k / 8];
        ep[row][col] = b[k % 8];
      end
    check({tag, ".weights"}, weights, ew);
    check({tag, ".pixels"}, pixels, ep);
    check({tag, ".load_done"}, load_done, exp_done);
    check({tag, ".chk_err"}, chk_err, exp_err);
  endtask

  function automatic logic [7:0] xor_of_frame();
    logic [7:0] x = 8'h00;
    for (int n = 0; n < 107; n++) x ^= frame[n];
    return x;
  endfunction

  task automatic fill_random(input bit good_chk);
    logic [7:0] x;
    for (int n = 0; n < 107; n++) frame[n] = 8'($urandom);
    x = xor_of_frame();
    if (FRAME_LEN > 107)
      frame[FRAME_LEN-1] = good_chk ? x : (x ^ 8'($urandom_range(1, 255)));
  endtask

  // Starts a frame from IDLE and pushes nsend bytes; gaps inserts an idle
  // cycle (data_valid low) before every byte.
  task automatic run_frame(input int nsend, input bit gaps);
    @(negedge clk);
    state      = 3'b001;
    data_valid = 1'b0;
    @(negedge clk);
    exp_err = 1'b0;
    for (int n = 0; n < nsend; n++) begin
      if (n > 0) @(negedge clk);
      if (gaps) begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        @(negedge clk);
      end
      data_valid = 1'b1;
      data_in    = frame[n];
      #1;
      check("data_ready_load", data_ready, 1'b1);
      if (n == FRAME_LEN - 1) check("load_done_before_last", load_done, 1'b0);
      @(posedge clk);
      #1;
      if (n < 9)        mem_w[n] = frame[n];
      else if (n < 107) mem_p[n-9] = frame[n];
      else              exp_err = (frame[n] != xor_of_frame());
    end
    data_valid = 1'b0;
    if (nsend == FRAME_LEN) check("load_done_rise", load_done, 1'b1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    state      = 3'b000;
    data_valid = 1'b1;
    data_in    = 8'($urandom);
    @(posedge clk);
    #1;
    check("ready_after_idle", data_ready, 1'b0);
    check_all("after_idle", 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    logic [27:0][27:0] rule_p;

    rst_n      = 1'b0;
    state      = 3'b000;
    data_in    = 8'h00;
    data_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    check("reset.data_ready", data_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones kernels, one set pixel per byte.
    for (int n = 0; n < 9; n++)   frame[n] = 8'hFF;
    for (int n = 9; n < 107; n++) frame[n] = 8'h01;
    if (FRAME_LEN > 107) frame[FRAME_LEN-1] = xor_of_frame();
    run_frame(FRAME_LEN, 1'b0);
    check_all("fixed_frame", 1'b1);
    check("fixed_frame.weights_ones", weights, {72{1'b1}});
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) rule_p[r][c] = (((r * 28 + c) % 8) == 0);
    check("fixed_frame.pixel_rule", pixels, rule_p);

    // DONE holds its outputs while valid bytes keep arriving.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 8'($urandom);
      #1;
      check("done.data_ready", data_ready, 1'b0);
      @(posedge clk);
      #1;
      check_all("done_hold", 1'b1);
    end
    go_idle();

    // Same random frame with and without gap cycles.
    fill_random(1'b1);
    foreach (frame[i]) frame_b[i] = frame[i];
    run_frame(FRAME_LEN, 1'b1);
    check_all("gapped_frame", 1'b1);
    go_idle();
    clear_model();
    for (int n = 0; n < 9; n++)   mem_w[n] = 8'h00;
    foreach (frame[i]) frame[i] = frame_b[i];
    run_frame(FRAME_LEN, 1'b0);
    check_all("dense_frame", 1'b1);
    go_idle();

    // Abort after 50 bytes by leaving the load state.
    fill_random(1'b1);
    run_frame(50, 1'b0);
    @(negedge clk);
    state      = 3'b010;
    data_valid = 1'b1;
    data_in    = 8'($urandom);
    #1;
    check("abort.data_ready", data_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort.ready_hold", data_ready, 1'b0);
      check_all("abort", 1'b0);
    end
    @(negedge clk);
    state      = 3'b000;
    data_valid = 1'b0;
    fill_random(1'b0);
    run_frame(FRAME_LEN, 1'b0);
    check_all("after_abort", 1'b1);
    go_idle();

    // Asynchronous reset at pixel byte 40.
    fill_random(1'b1);
    run_frame(49, 1'b0);
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    #1;
    clear_model();
    check_all("mid_reset", 1'b0);
    check("mid_reset.data_ready", data_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    state = 3'b000;
    fill_random(1'b1);
    run_frame(FRAME_LEN, 1'b0);
    check_all("after_reset", 1'b1);
    go_idle();

`ifdef LOADER_CHKSUM_EN
    for (int n = 0; n < 107; n++) frame[n] = 8'hA5;
    frame[107] = 8'hA5;
    run_frame(FRAME_LEN, 1'b0);
    check("a5_good.chk_err", chk_err, 1'b0);
    check_all("a5_good", 1'b1);
    go_idle();
    frame[107] = 8'h00;
    run_frame(FRAME_LEN, 1'b0);
    check("a5_bad.chk_err", chk_err, 1'b1);
    check("a5_bad.load_done", load_done, 1'b1);
    check_all("a5_bad", 1'b1);
    go_idle();
`endif

    for (int t = 0; t < 3; t++) begin
      fill_random(($urandom & 1) == 1);
      run_frame(FRAME_LEN, ($urandom & 1) == 1);
      check_all("random_frame", 1'b1);
      go_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 SHALL have parameter LOAD_STATE, default 3'b001, the top-level state code in which loading is enabled.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port state  input  3  top-level state code.
REQ-005 SHALL have port data_in  input  8  byte from the input pins.
REQ-006 SHALL have port data_valid  input  1  data_in holds a valid byte this cycle.
REQ-007 SHALL have port data_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port weights  output  [7:0][2:0][2:0]  eight 3x3 binary kernels.
REQ-009 SHALL have port pixels  output  [27:0][27:0]  binary image, pixels[row][col].
REQ-010 SHALL have port load_done  output  1  full frame captured.
REQ-011 SHALL have port chk_err  output  1  checksum mismatch on the last frame.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, LOAD_P, CHECK, DONE.
REQ-013 SHALL accept a byte only on a cycle where data_valid & data_ready = 1; no other byte is consumed.
REQ-014 SHALL drive data_ready = 1 only in LOAD_W, LOAD_P or CHECK while state == LOAD_STATE.
REQ-015 IDLE -> LOAD_W on state == LOAD_STATE; the byte counter is cleared on entry.
REQ-016 LOAD_W: 9 bytes; byte n bit i -> weight index k = 8n+i, mapping k = num*9 + r*3 + c to weights[num][r][c] (LSB first).
REQ-017 LOAD_W -> LOAD_P after the 9th accepted byte; the counter restarts at 0.
REQ-018 LOAD_P: 98 bytes; byte n bit i -> pixel index k = 8n+i, mapping k = row*28 + col to pixels[row][col].
REQ-019 After the 98th pixel byte: -> CHECK if LOADER_CHKSUM_EN is defined, else -> DONE.
REQ-020 SHALL hold load_done = 1 in DONE and 0 in every other state; it rises the cycle after the final byte is accepted.
REQ-021 DONE -> IDLE when state == 3'b000; load_done clears on that transition.
REQ-022 Mid-load abort: state != LOAD_STATE while in LOAD_W/LOAD_P/CHECK -> IDLE next cycle; counter cleared, load_done stays 0, partially written weights/pixels retained.
REQ-023 The byte counter SHALL be 7 bits and SHALL never exceed 97; there is no wrap, since phase change occurs at its terminal count.
REQ-024 weights/pixels bits SHALL change only on an accepted byte; outputs are stable in DONE.
REQ-025 Re-entry to LOAD_STATE from IDLE SHALL start a new frame; a new frame overwrites weights and pixels.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counter 0, data_ready 0, load_done 0, chk_err 0, weights all 0, pixels all 0.
REQ-027 Reset release SHALL take effect on the first clk edge with rst_n high; reset applied mid-frame discards the frame.

Configuration
REQ-028 Macro LOADER_CHKSUM_EN defined: a running XOR of all 107 weight and pixel bytes is kept; CHECK accepts one extra byte and then -> DONE; chk_err = (byte != XOR), held until the next frame starts or reset.
REQ-029 LOADER_CHKSUM_EN undefined: no CHECK state logic, 107-byte frame, chk_err tied to 0.

Verification
REQ-030 Reset mid-LOAD_P (byte 40) -> next cycle all outputs 0, FSM IDLE; reload of a full frame completes normally.
REQ-031 Frame: 9 weight bytes 8'hFF, 98 pixel bytes 8'h01 -> weights all 1; pixels[r][c] = 1 iff (r*28+c)%8 == 0; load_done rises 1 cycle after the last byte.
REQ-032 data_valid toggled 1/0 every cycle, same frame -> identical outputs; byte count unaffected by idle cycles.
REQ-033 state forced to 3'b010 after 50 bytes -> IDLE, load_done 0; data_ready 0 while state != 3'b001.
REQ-034 With LOADER_CHKSUM_EN, frame of all 8'hA5 (107 bytes, XOR = 8'hA5), check byte 8'hA5 -> chk_err 0; check byte 8'h00 -> chk_err 1, load_done 1.
REQ-035 In DONE, state = 3'b000 -> load_done 0 next cycle, weights/pixels unchanged.
